// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a 1W/1R register-file macro with a 2-entry show-ahead output buffer.
// Optional FIFO_BYPASS_EN: pushes into an empty FIFO skip the SRAM and land in the output buffer.
module sram_fifo_ctrl #(
  parameter int WWORD = 64,
  parameter int WADDR = 9,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WWORD-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WWORD-1:0] out_data,
  output logic [WADDR+1:0] count,
  output logic [WADDR-1:0] sram_aa,
  output logic             sram_cena,
  input  logic [WWORD-1:0] sram_qa,
  output logic [WADDR-1:0] sram_ab,
  output logic [WWORD-1:0] sram_db,
  output logic             sram_cenb
);

  localparam logic [WADDR-1:0] LAST    = WADDR'(DEPTH - 1);
  localparam logic [WADDR:0]   MEM_MAX = (WADDR + 1)'(DEPTH);

  logic [WADDR-1:0] r_wr_ptr, r_rd_ptr;
  logic [WADDR:0]   r_mem_cnt;
  logic             r_inflight;
  logic [1:0]       r_buf_cnt;
  logic [WWORD-1:0] r_buf0, r_buf1;
  logic [WADDR+1:0] r_count;

  logic             w_push, w_pop, w_byp, w_wr, w_issue, w_cap;
  logic [1:0]       w_buf_left, w_pend;
  logic [WWORD-1:0] w_cap_data;

  assign in_ready   = !rst && (r_mem_cnt < MEM_MAX);
  assign out_valid  = (r_buf_cnt != 2'd0);
  assign out_data   = r_buf0;
  assign count      = r_count;

  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign w_buf_left = r_buf_cnt - {1'b0, w_pop};
  // buffered + in-flight words that will remain after this cycle's pop
  assign w_pend     = w_buf_left + {1'b0, r_inflight};

`ifdef FIFO_BYPASS_EN
  assign w_byp = w_push && (r_mem_cnt == '0) && !r_inflight && (w_buf_left < 2'd2);
`else
  assign w_byp = 1'b0;
`endif

  assign w_wr       = w_push & ~w_byp;
  assign w_issue    = (r_mem_cnt != '0) && (w_pend < 2'd2);
  assign w_cap      = r_inflight | w_byp;
  assign w_cap_data = r_inflight ? sram_qa : in_data;

  assign sram_cena  = ~w_issue;
  assign sram_aa    = r_rd_ptr;
  assign sram_cenb  = ~w_wr;
  assign sram_ab    = r_wr_ptr;
  assign sram_db    = in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_wr)    r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      r_mem_cnt  <= r_mem_cnt + {{WADDR{1'b0}}, w_wr} - {{WADDR{1'b0}}, w_issue};
      r_inflight <= w_issue;
      r_count    <= r_count + {{(WADDR+1){1'b0}}, w_push} - {{(WADDR+1){1'b0}}, w_pop};
    end
  end

  // Pop shift and tail capture share one edge; the capture lands behind whatever survives the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_buf_cnt <= '0;
    end else begin
      if (w_pop) r_buf0 <= r_buf1;
      if (w_cap) begin
        if (w_buf_left == 2'd0) r_buf0 <= w_cap_data;
        else                    r_buf1 <= w_cap_data;
      end
      r_buf_cnt <= w_buf_left + {1'b0, w_cap};
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: vector table, directed corner sequences and a random run
// against a queue scoreboard; a second DEPTH=12 instance covers non-power-of-2 wrap.
module tb_sram_fifo_ctrl;
  localparam int WW = 64, WA = 9, DP = 512;
  localparam int SWA = 4, SDP = 12;
`ifdef FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WW-1:0] in_data, out_data, sram_qa, sram_db;
  logic [WA+1:0] count;
  logic [WA-1:0] sram_aa, sram_ab;
  logic sram_cena, sram_cenb;

  sram_fifo_ctrl #(.WWORD(WW), .WADDR(WA), .DEPTH(DP)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .sram_aa(sram_aa), .sram_cena(sram_cena), .sram_qa(sram_qa),
    .sram_ab(sram_ab), .sram_db(sram_db), .sram_cenb(sram_cenb));

  logic [WW-1:0] mem [0:DP-1];
  always @(posedge clk) begin
    if (!sram_cenb) mem[sram_ab] <= sram_db;
    if (!sram_cena) sram_qa <= mem[sram_aa];
  end

  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [WW-1:0] s_in_data, s_out_data, s_qa, s_db;
  logic [SWA+1:0] s_count;
  logic [SWA-1:0] s_aa, s_ab;
  logic s_cena, s_cenb;

  sram_fifo_ctrl #(.WWORD(WW), .WADDR(SWA), .DEPTH(SDP)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .count(s_count),
    .sram_aa(s_aa), .sram_cena(s_cena), .sram_qa(s_qa),
    .sram_ab(s_ab), .sram_db(s_db), .sram_cenb(s_cenb));

  logic [WW-1:0] smem [0:SDP-1];
  always @(posedge clk) begin
    if (!s_cenb) smem[s_ab] <= s_db;
    if (!s_cena) s_qa <= smem[s_aa];
  end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: FIFO contents as a queue, SRAM occupancy from observed enables.
  logic [WW-1:0] q[$];
  int occ = 0, npush = 0;
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("count", 64'(count), 64'(q.size()));
      if (out_valid) chk("ov_nonempty", 64'(q.size() != 0), 64'd1);
      if (!sram_cena && !sram_cenb) chk("addr_collide", 64'(sram_aa != sram_ab), 64'd1);
      if (!sram_cena) chk("rd_nonempty", 64'(occ > 0), 64'd1);
      if (!sram_cenb) chk("wr_notfull", 64'(occ < DP), 64'd1);
      chk("held_le2", 64'((q.size() - occ) <= 2), 64'd1);
      if (!sram_cenb) occ++;
      if (!sram_cena) occ--;
      if (out_valid && out_ready && q.size() != 0) chk("pop_data", out_data, q.pop_front());
      if (in_valid && in_ready) begin q.push_back(in_data); npush++; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill(input int want, input logic [63:0] base, output int got);
    got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < want + 100; c++) begin
      in_valid = (got < want);
      in_data  = base + 64'(got);
      @(negedge clk);
      if (in_valid && in_ready) got++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic s_round(input logic [63:0] base, input int want, input int exp_n);
    int sn, k;
    sn = 0; k = 0;
    s_out_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      s_in_valid = (sn < want);
      s_in_data  = base + 64'(sn);
      @(negedge clk);
      if (s_in_valid && s_in_ready) sn++;
      tick();
    end
    s_in_valid = 1'b0;
    chk("s_fill_n", 64'(sn), 64'(exp_n));
    chk("s_fill_cnt", 64'(s_count), 64'(exp_n));
    if (exp_n == SDP + 2) chk("s_full_rdy", 64'(s_in_ready), 64'd0);
    s_out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_out_valid) begin
        chk("s_drain_data", s_out_data, base + 64'(k));
        k++;
      end
      tick();
    end
    s_out_ready = 1'b0;
    chk("s_drain_n", 64'(k), 64'(exp_n));
    chk("s_empty_ov", 64'(s_out_valid), 64'd0);
    chk("s_empty_cnt", 64'(s_count), 64'd0);
  endtask

  typedef struct {
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic        ov;
    logic [63:0] od;
    int          cnt;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int got, k, nv, first, last;
    logic [WA-1:0] prev_ab;
    bit wrapped;

    tbl[0] = '{1'b1, 64'd11, 1'b0, 1'b0, 64'd0,  0};
    tbl[1] = '{1'b1, 64'd22, 1'b0, BYP,  64'd11, 1};
    tbl[2] = '{1'b0, 64'd0,  1'b0, BYP,  64'd11, 2};
    tbl[3] = '{1'b0, 64'd0,  1'b1, 1'b1, 64'd11, 2};
    tbl[4] = '{1'b0, 64'd0,  1'b1, 1'b1, 64'd22, 1};
    tbl[5] = '{1'b0, 64'd0,  1'b0, 1'b0, 64'd0,  0};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_od", out_data, 64'd0);
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_cena", 64'(sram_cena), 64'd1);
    chk("rst_cenb", 64'(sram_cenb), 64'd1);
    rst = 1'b0;
    tick();
    chk("post_rst_rdy", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    // vector table, one entry per cycle from empty
    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      #1;
      chk("tbl_ov", 64'(out_valid), 64'(tbl[i].ov));
      chk("tbl_cnt", 64'(count), 64'(tbl[i].cnt));
      if (tbl[i].ov) chk("tbl_od", out_data, tbl[i].od);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) tick();

    // single push latency
    in_valid = 1'b1; in_data = 64'hA5; out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; in_valid = 1'b0; #1;
      k++;
      if (out_valid) break;
    end
    chk("lat", 64'(k), 64'(LAT));
    chk("lat_od", out_data, 64'hA5);
    repeat (2) tick();
    chk("lat_cnt0", 64'(count), 64'd0);
    chk("lat_ov0", 64'(out_valid), 64'd0);

    // full fill then ordered drain
    fill(600, 64'd0, got);
    chk("full_n", 64'(got), 64'(DP + 2));
    chk("full_cnt", 64'(count), 64'(DP + 2));
    chk("full_rdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    nv = 0; first = -1; last = -1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (out_valid) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
      tick();
    end
    chk("drain_n", 64'(nv), 64'(DP + 2));
    chk("drain_nobubble", 64'(last - first + 1), 64'(DP + 2));
    chk("drain_ov0", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // sustained push+pop with a standing prefill of 6
    fill(6, 64'h1000, got);
    repeat (6) tick();
    wrapped = 1'b0; prev_ab = '0;
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'b1; in_data = 64'h2000 + 64'(i); out_ready = 1'b1;
      #1;
      chk("cont_cena", 64'(sram_cena), 64'd0);
      chk("cont_cenb", 64'(sram_cenb), 64'd0);
      chk("cont_cnt", 64'(count), 64'd6);
      if (i > 0 && prev_ab == WA'(DP - 1) && sram_ab == '0) wrapped = 1'b1;
      prev_ab = sram_ab;
      @(posedge clk); #1;
    end
    chk("cont_wrap", 64'(wrapped), 64'd1);
    in_valid = 1'b0;
    repeat (10) tick();
    chk("cont_empty", 64'(count), 64'd0);

    // random pop pressure, continuous push
    npush = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 40000 && npush < 10000; c++) begin
      out_ready = 1'($urandom_range(1));
      in_data   = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("rand_done", 64'(npush >= 10000), 64'd1);
    repeat (600) tick();
    chk("rand_empty", 64'(count), 64'd0);
    chk("rand_ov0", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // reset while a read is in flight
    fill(38, 64'h3000, got);
    repeat (5) tick();
    chk("mid_pre_cnt", 64'(count), 64'd38);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("mid_cnt37", 64'(count), 64'd37);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_ov", 64'(out_valid), 64'd0);
    chk("mid_cnt", 64'(count), 64'd0);
    chk("mid_rdy", 64'(in_ready), 64'd0);
    q.delete(); occ = 0;
    repeat (3) tick();
    chk("mid_rdy_hold", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    in_valid = 1'b1; in_data = 64'h1; out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; in_valid = 1'b0; #1;
      k++;
      if (out_valid) break;
    end
    chk("mid_first_ov", 64'(out_valid), 64'd1);
    chk("mid_first_od", out_data, 64'h1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("mid_after_ov", 64'(out_valid), 64'd0);
    chk("mid_after_cnt", 64'(count), 64'd0);
    out_ready = 1'b0;

    // DEPTH=12 instance: partial round shifts pointers, then full round wraps 11->0
    s_round(64'h100, 5, 5);
    s_round(64'h200, 30, SDP + 2);
    s_round(64'h300, 30, SDP + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Synchronous FIFO controller that sequences one external 1-write/1-read register-file macro (rfdp family, one-cycle registered read, active-low chip enables) as FIFO storage. It presents valid/ready push and pop interfaces and hides the SRAM read latency with a 2-entry show-ahead output buffer. It is used between pipeline stages of the codec, such as the DCT-to-entropy and line buffers, wherever a deep FIFO must be held in macro SRAM rather than flops.

Parameters:
WWORD, 64, data word width in bits; must match the SRAM macro width.
WADDR, 9, SRAM address width.
DEPTH, 512, SRAM entries; need not be a power of 2, must be at least 2 and no more than 2^WADDR.

Ports:
clk  in  1  single clock for the controller and both SRAM ports
rst  in  1  asynchronous, active-high reset
in_valid  in  1  push request
in_ready  out  1  push accept; a push occurs when in_valid & in_ready
in_data  in  WWORD  push data
out_valid  out  1  head of FIFO valid
out_ready  in  1  pop accept; a pop occurs when out_valid & out_ready
out_data  out  WWORD  head data, registered
count  out  WADDR+2  total words held: SRAM + in flight + output buffer
sram_aa  out  WADDR  SRAM read address
sram_cena  out  1  SRAM read enable, active low
sram_qa  in  WWORD  SRAM read data, valid the cycle after sram_cena=0
sram_ab  out  WADDR  SRAM write address
sram_db  out  WWORD  SRAM write data
sram_cenb  out  1  SRAM write enable, active low

Behaviour:
- Reset state: pointers, mem_cnt, inflight, buf_cnt and count are 0; out_valid=0; out_data=0; sram_cena=sram_cenb=1. in_ready is forced to 0 while rst is high.
- Reset asserted mid-operation: all contents and any in-flight read are discarded; the returned sram_qa is ignored.
- State elements:
  - wr_ptr and rd_ptr, each 0..DEPTH-1, wrap DEPTH-1 -> 0.
  - mem_cnt, 0..DEPTH.
  - inflight, 0/1.
  - 2-entry output buffer with buf_cnt 0..2.
- Push:
  - in_ready = (mem_cnt < DEPTH), combinational.
  - On a push: sram_cenb=0, sram_ab=wr_ptr, sram_db=in_data, all in the same cycle. wr_ptr advances at the clock edge.
- Read issue: sram_cena=0 when mem_cnt>0 and (buf_cnt + inflight - pop_this_cycle) < 2, with sram_aa=rd_ptr. rd_ptr advances and inflight is set for the next cycle.
- Capture: when inflight=1, sram_qa is written into the output buffer tail at the clock edge.
- Read/write address collision cannot occur: a read requires mem_cnt>0, and a write requires mem_cnt<DEPTH. Same-cycle push and read issue are both legal.
- mem_cnt update is +push -issue; count update is +push -pop. Simultaneous push and pop leave count unchanged.
- Pop: out_valid = (buf_cnt > 0). out_data is the buffer head register. On a pop, the next entry shifts to the head in the same edge as any capture.
- Latency (feature off): push in cycle N -> out_valid=1 in cycle N+3 when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained, with no bubbles.
- Full: count = DEPTH+2 maximum; in_ready=0 once mem_cnt=DEPTH.
- Empty: out_valid=0; out_ready is ignored.

Optional Feature:
FIFO_BYPASS_EN
- Defined: when mem_cnt=0, inflight=0 and buf_cnt<2 (after this cycle's pop), a push writes in_data directly into the output buffer and does not touch the SRAM (sram_cenb stays 1). Empty-FIFO latency becomes 1 cycle: push in cycle N -> out_valid in N+1.
- Ordering is preserved, because bypass is used only when no older word sits in the SRAM or is in flight.
- Undefined: every word goes through the SRAM, with the 3-cycle empty latency above.

Test Plan:
- Single push of 0xA5 into an empty FIFO, out_ready=1 -> out_valid rises in cycle N+3 (N+1 with FIFO_BYPASS_EN), out_data=0xA5, count returns to 0.
- 514 pushes (values 0..513) with out_ready=0, DEPTH=512 -> in_ready drops after the 514th push and count=514. Then drain with out_ready=1 -> values 0..513 in order, one per cycle after the first valid, out_valid=0 at the end.
- Continuous push and pop for 2000 cycles -> pointers wrap at 511->0 with no data loss. count is steady, and sram_cena/sram_cenb are each low every cycle after fill.
- Random out_ready (50%) with continuous in_valid, 10000 words -> scoreboard matches. No read issued when buffer+inflight=2, and sram_aa never equals sram_ab while both enables are low.
- Assert rst while a read is in flight with count=37 -> out_valid=0, count=0, and in_ready=0 during reset. After release, a push of 0x1 yields 0x1 as the first output and no stale data.
- DEPTH=12 build (non-power-of-2) with a full fill and drain -> pointers wrap 11->0 and data order is preserved.
